// File: rtl/apu_pkg.sv
// Shared constants for the APU tone-channel envelope/length logic:
// length-load table, register addresses and datapath widths.
package apu_pkg;

  localparam int LEN_W = 8;
  localparam int VOL_W = 4;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_LEN  = 2'd3;

  localparam logic [7:0] LEN_TABLE [0:31] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    return LEN_TABLE[idx];
  endfunction

endpackage

// File: rtl/envelope_length_unit_envelope_gen.sv
// Decaying envelope: start flag, period divider and decay counter with
// optional loop, stepped once per quarter-frame event pulse.
module envelope_gen #(
  parameter int VOL_W = apu_pkg::VOL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qtr_evt,
  input  logic             start_set,
  input  logic             halt_loop,
  input  logic [VOL_W-1:0] period,
  output logic [VOL_W-1:0] decay
);

  localparam logic [VOL_W-1:0] DECAY_MAX = {VOL_W{1'b1}};

  logic             start_q, start_d;
  logic [VOL_W-1:0] div_q, div_d;
  logic [VOL_W-1:0] decay_q, decay_d;

  always_comb begin
    start_d = start_q;
    div_d   = div_q;
    decay_d = decay_q;
    if (qtr_evt) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = DECAY_MAX;
        div_d   = period;
      end else if (div_q == '0) begin
        div_d = period;
        if (decay_q != '0) begin
          decay_d = decay_q - 1'b1;
        end else if (halt_loop) begin
          decay_d = DECAY_MAX;
        end
      end else begin
        div_d = div_q - 1'b1;
      end
    end
    // A length write landing on a quarter event re-arms after the step.
    if (start_set) begin
      start_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      div_q   <= '0;
      decay_q <= '0;
    end else begin
      start_q <= start_d;
      div_q   <= div_d;
      decay_q <= decay_d;
    end
  end

  assign decay = decay_q;

endmodule

// File: rtl/envelope_length_unit.sv
// Tone-channel envelope and length unit fed by the frame sequencer.
// Define FRAME_SYNC_EN to add a two-flop synchronizer ahead of edge detect.
module envelope_length_unit #(
  parameter int LEN_W = apu_pkg::LEN_W,
  parameter int VOL_W = apu_pkg::VOL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qtr_clk,
  input  logic             hlf_clk,
  input  logic             chan_en,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [7:0]       reg_data,
  output logic [VOL_W-1:0] volume,
  output logic             active
);

  import apu_pkg::*;

  logic             qtr_src, hlf_src;
  logic             qtr_q, qtr_d, hlf_q, hlf_d;
  logic             qtr_evt, hlf_evt;
  logic             ctrl_wr, len_wr;
  logic             halt_loop_q, halt_loop_d;
  logic             const_vol_q, const_vol_d;
  logic [VOL_W-1:0] period_q, period_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic [VOL_W-1:0] volume_q, volume_d;
  logic             active_q, active_d;
  logic [VOL_W-1:0] decay;

`ifdef FRAME_SYNC_EN
  logic [1:0] qtr_sync_q, qtr_sync_d;
  logic [1:0] hlf_sync_q, hlf_sync_d;

  assign qtr_sync_d = {qtr_sync_q[0], qtr_clk};
  assign hlf_sync_d = {hlf_sync_q[0], hlf_clk};

  always_ff @(posedge clk) begin
    if (rst) begin
      qtr_sync_q <= '0;
      hlf_sync_q <= '0;
    end else begin
      qtr_sync_q <= qtr_sync_d;
      hlf_sync_q <= hlf_sync_d;
    end
  end

  assign qtr_src = qtr_sync_q[1];
  assign hlf_src = hlf_sync_q[1];
`else
  assign qtr_src = qtr_clk;
  assign hlf_src = hlf_clk;
`endif

  assign qtr_evt = qtr_src & ~qtr_q;
  assign hlf_evt = hlf_src & ~hlf_q;
  assign ctrl_wr = reg_we && (reg_addr == REG_CTRL);
  assign len_wr  = reg_we && (reg_addr == REG_LEN);

  envelope_gen #(
    .VOL_W(VOL_W)
  ) u_env (
    .clk      (clk),
    .rst      (rst),
    .qtr_evt  (qtr_evt),
    .start_set(len_wr),
    .halt_loop(halt_loop_q),
    .period   (period_q),
    .decay    (decay)
  );

  always_comb begin
    qtr_d       = qtr_src;
    hlf_d       = hlf_src;
    halt_loop_d = halt_loop_q;
    const_vol_d = const_vol_q;
    period_d    = period_q;
    length_d    = length_q;

    if (ctrl_wr) begin
      halt_loop_d = reg_data[5];
      const_vol_d = reg_data[4];
      period_d    = VOL_W'(reg_data[3:0]);
    end

    // Disabled channel pins length at zero; a load beats a same-cycle decrement.
    if (!chan_en) begin
      length_d = '0;
    end else if (len_wr) begin
      length_d = LEN_W'(len_lookup(reg_data[7:3]));
    end else if (hlf_evt && !halt_loop_q && (length_q != '0)) begin
      length_d = length_q - 1'b1;
    end

    active_d = (length_q != '0);
    if (length_q == '0) begin
      volume_d = '0;
    end else if (const_vol_q) begin
      volume_d = period_q;
    end else begin
      volume_d = decay;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qtr_q       <= 1'b0;
      hlf_q       <= 1'b0;
      halt_loop_q <= 1'b0;
      const_vol_q <= 1'b0;
      period_q    <= '0;
      length_q    <= '0;
      volume_q    <= '0;
      active_q    <= 1'b0;
    end else begin
      qtr_q       <= qtr_d;
      hlf_q       <= hlf_d;
      halt_loop_q <= halt_loop_d;
      const_vol_q <= const_vol_d;
      period_q    <= period_d;
      length_q    <= length_d;
      volume_q    <= volume_d;
      active_q    <= active_d;
    end
  end

  assign volume = volume_q;
  assign active = active_q;

endmodule

// File: tb/tb_envelope_length_unit.sv
// Self-checking bench for envelope_length_unit: constant vector table,
// directed corner sequences and random traffic against a behavioural model.
module tb_envelope_length_unit;

`ifdef FRAME_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, qtr_clk, hlf_clk, chan_en, reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_data;
  logic [3:0] volume;
  logic       active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  envelope_length_unit dut (
    .clk     (clk),
    .rst     (rst),
    .qtr_clk (qtr_clk),
    .hlf_clk (hlf_clk),
    .chan_en (chan_en),
    .reg_we  (reg_we),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .volume  (volume),
    .active  (active)
  );

  int tb_len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                          12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // Behavioural model state, plain integers.
  int m_len, m_decay, m_div, m_start, m_halt, m_cv, m_per;
  int m_qprev, m_hprev, m_qs1, m_qs2, m_hs1, m_hs2;
  int m_exp_vol, m_exp_act;

  function automatic void model_reset();
    m_len = 0; m_decay = 0; m_div = 0; m_start = 0;
    m_halt = 0; m_cv = 0; m_per = 0;
    m_qprev = 0; m_hprev = 0; m_qs1 = 0; m_qs2 = 0; m_hs1 = 0; m_hs2 = 0;
    m_exp_vol = 0; m_exp_act = 0;
  endfunction

  function automatic void model_step();
    int qin, hin, qe, he, wl, wc;
    if (rst) begin
      model_reset();
      return;
    end
    m_exp_act = (m_len != 0);
    m_exp_vol = (m_len == 0) ? 0 : (m_cv != 0 ? m_per : m_decay);
    qin = (LAT != 0) ? m_qs2 : int'(qtr_clk);
    hin = (LAT != 0) ? m_hs2 : int'(hlf_clk);
    qe = (qin == 1 && m_qprev == 0);
    he = (hin == 1 && m_hprev == 0);
    m_qprev = qin; m_hprev = hin;
    m_qs2 = m_qs1; m_qs1 = int'(qtr_clk);
    m_hs2 = m_hs1; m_hs1 = int'(hlf_clk);
    wl = reg_we && reg_addr == 2'd3;
    wc = reg_we && reg_addr == 2'd0;
    if (qe) begin
      if (m_start) begin
        m_start = 0; m_decay = 15; m_div = m_per;
      end else if (m_div == 0) begin
        m_div = m_per;
        m_decay = (m_decay > 0) ? m_decay - 1 : (m_halt ? 15 : 0);
      end else begin
        m_div = m_div - 1;
      end
    end
    if (wl) m_start = 1;
    if (!chan_en) m_len = 0;
    else if (wl) m_len = tb_len_tab[reg_data[7:3]];
    else if (he && !m_halt && m_len > 0) m_len = m_len - 1;
    if (wc) begin
      m_halt = reg_data[5]; m_cv = reg_data[4]; m_per = reg_data[3:0];
    end
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input int exp);
    checks++;
    if (act !== exp[7:0]) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_volume", {4'd0, volume}, m_exp_vol);
    check("model_active", {7'd0, active}, m_exp_act);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_data = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic pulse_q();
    qtr_clk = 1'b1; tick(); tick();
    qtr_clk = 1'b0; tick(); tick();
  endtask

  task automatic pulse_h();
    hlf_clk = 1'b1; tick(); tick();
    hlf_clk = 1'b0; tick(); tick();
  endtask

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    logic       en;
    logic       q;
    logic       h;
    int         vol;
    int         act;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 2'd3, 8'h18, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1};
    tbl[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[10] = '{1'b1, 2'd0, 8'h17, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[11] = '{1'b1, 2'd3, 8'h08, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 7, 1};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 7, 1};
    tbl[14] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 7, 1};
    tbl[15] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7, 1};
    tbl[16] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[17] = '{1'b1, 2'd3, 8'h18, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[18] = '{1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 7, 1};
    tbl[19] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 15, 1};

    model_reset();
    rst = 1'b1; qtr_clk = 1'b0; hlf_clk = 1'b0; chan_en = 1'b1;
    reg_we = 1'b0; reg_addr = 2'd0; reg_data = 8'h00;

    // Reset held three cycles while the frame clocks toggle.
    for (int i = 0; i < 3; i++) begin
      qtr_clk = ~qtr_clk; hlf_clk = ~hlf_clk;
      tick();
      check("reset_volume", {4'd0, volume}, 0);
      check("reset_active", {7'd0, active}, 0);
    end
    qtr_clk = 1'b0; hlf_clk = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      reg_we = tbl[i].we; reg_addr = tbl[i].addr; reg_data = tbl[i].data;
      chan_en = tbl[i].en; qtr_clk = tbl[i].q; hlf_clk = tbl[i].h;
      tick();
`ifndef FRAME_SYNC_EN
      check($sformatf("tbl%0d_volume", i), {4'd0, volume}, tbl[i].vol);
      check($sformatf("tbl%0d_active", i), {7'd0, active}, tbl[i].act);
`endif
    end
    reg_we = 1'b0; qtr_clk = 1'b0; hlf_clk = 1'b0; chan_en = 1'b1;
    tick(); tick(); tick();

    // Envelope decay, period 1, no loop.
    wr(2'd0, 8'h01); wr(2'd3, 8'h08);
    for (int k = 1; k <= 33; k++) begin
      pulse_q();
      check($sformatf("decay_k%0d", k), {4'd0, volume}, (k <= 31) ? 15 - (k - 1) / 2 : 0);
    end

    // Same with loop: reloads to 15 after reaching 0.
    wr(2'd0, 8'h21); wr(2'd3, 8'h08);
    for (int k = 1; k <= 33; k++) begin
      pulse_q();
      check($sformatf("loop_k%0d", k), {4'd0, volume},
            (k <= 31) ? 15 - (k - 1) / 2 : ((k == 32) ? 0 : 15));
    end
    wr(2'd3, 8'h18);
    for (int k = 0; k < 3; k++) pulse_h();
    check("halt_no_decrement", {7'd0, active}, 1);
    wr(2'd0, 8'h00);
    pulse_h(); pulse_h();
    check("len2_expired", {7'd0, active}, 0);

    // Length write coincident with a half-frame event at length 5.
    wr(2'd3, 8'h38);
    pulse_h();
    hlf_clk = 1'b1;
    repeat (LAT) tick();
    wr(2'd3, 8'h00);
    tick(); hlf_clk = 1'b0; tick(); tick();
    check("hlf_collision_active", {7'd0, active}, 1);
    for (int k = 1; k <= 10; k++) begin
      pulse_h();
      check($sformatf("hlf_coll_len_k%0d", k), {7'd0, active}, (k < 10) ? 1 : 0);
    end

    // Length write coincident with a quarter-frame event.
    wr(2'd3, 8'h08);
    pulse_q();
    check("qcoll_start", {4'd0, volume}, 15);
    pulse_q();
    check("qcoll_pre", {4'd0, volume}, 14);
    qtr_clk = 1'b1;
    repeat (LAT) tick();
    wr(2'd3, 8'h08);
    tick(); qtr_clk = 1'b0; tick(); tick();
    check("qcoll_step_old_state", {4'd0, volume}, 13);
    pulse_q();
    check("qcoll_restart", {4'd0, volume}, 15);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) qtr_clk = ~qtr_clk;
      if ($urandom_range(0, 5) == 0) hlf_clk = ~hlf_clk;
      chan_en = ($urandom_range(0, 29) != 0);
      reg_we = ($urandom_range(0, 9) == 0);
      reg_addr = 2'($urandom_range(0, 3));
      reg_data = 8'($urandom);
      tick();
    end
    rst = 1'b0; reg_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
